// File: rtl/seq_detect_sched_pkg.sv
// Shared types and constants for the two-requester pattern detector scheduler.
package seq_detect_sched_pkg;

    localparam int W     = 8;                 // bits per frame
    localparam int PW    = 8;                 // maximum pattern length
    localparam int LEN_W = $clog2(PW + 1);
    localparam int POS_W = $clog2(W);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Detector configuration, latched at grant and held for the whole frame.
    typedef struct packed {
        logic [PW-1:0]    pattern;
        logic [LEN_W-1:0] len;
        logic             overlap;
    } cfg_t;

    // A length of zero or beyond the history depth cannot be matched.
    function automatic logic len_bad(input logic [LEN_W-1:0] len);
        return (len == '0) || (int'(len) > PW);
    endfunction

endpackage

// File: rtl/seq_detect_sched_if.sv
// Requester handshake and match report bundle.
interface seq_detect_sched_if;
    import seq_detect_sched_pkg::*;

    logic             req0_valid;
    logic [W-1:0]     req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [W-1:0]     req1_data;
    logic             req1_ready;
    logic             busy;
    logic             match_pulse;
    logic             match_ch;
    logic [POS_W-1:0] match_pos;

    // Requester / status side.
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, busy, match_pulse, match_ch, match_pos
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, busy, match_pulse, match_ch, match_pos
    );

endinterface

// File: rtl/seq_match_core.sv
// Serial Mealy-style detector: history shift register plus a saturating bit
// count, so a match needs at least len bits seen since the last reset point.
module seq_match_core
    import seq_detect_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic bit_vld,
    input  logic bit_in,
    input  cfg_t cfg,
    output logic hit
);

    logic [PW-1:0]    hist_q, hist_d, mask;
    logic [LEN_W-1:0] nb_q, nb_d, nb_inc;

    // Evaluate the incoming bit against the post-shift history.
    always_comb begin
        hist_d = {hist_q[PW-2:0], bit_in};
        nb_inc = (nb_q == LEN_W'(PW)) ? nb_q : nb_q + LEN_W'(1);
        mask   = ~({PW{1'b1}} << cfg.len);
        hit    = bit_vld && (nb_inc >= cfg.len) &&
                 ((hist_d & mask) == (cfg.pattern & mask));
        // Non-overlap restarts the count so the next match uses fresh bits only.
        nb_d   = (hit && !cfg.overlap) ? '0 : nb_inc;
    end

    // History state; cleared at each grant so matches never span words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            nb_q   <= '0;
        end else if (clr) begin
            hist_q <= '0;
            nb_q   <= '0;
        end else if (bit_vld) begin
            hist_q <= hist_d;
            nb_q   <= nb_d;
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that serializes granted words MSB-first through one
// shared detector and keeps per-channel saturating match counters.
module seq_detect_sched
    import seq_detect_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [PW-1:0]     cfg_pattern,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_overlap,
    output logic              cfg_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  match_cnt0,
    output logic [CNT_W-1:0]  match_cnt1,
    seq_detect_sched_if.slave req
);

    state_e           state_q;
    logic [W-1:0]     data_q;
    logic [POS_W-1:0] pos_q;
    logic             ch_q;
    logic             last_q;     // channel granted last; resets to 1 so ch0 wins first
    cfg_t             cfg_q;

    logic             grant_ok, gnt0, gnt1, grant, hit;
    logic             pulse_q, mch_q;
    logic [POS_W-1:0] mpos_q;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    assign cfg_err = len_bad(cfg_len);

    // Grant only from IDLE; with both valid, the channel not served last wins.
    always_comb begin
        grant_ok = rst_n && (state_q == IDLE) && cfg_en && !cfg_err;
        gnt0     = grant_ok && req.req0_valid && (!req.req1_valid || last_q);
        gnt1     = grant_ok && req.req1_valid && (!req.req0_valid || !last_q);
        grant    = gnt0 || gnt1;
    end

    assign req.req0_ready = gnt0;
    assign req.req1_ready = gnt1;
    assign req.busy       = (state_q == SHIFT);

    // Frame FSM: latch word and config at grant, then shift out W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            pos_q   <= '0;
            ch_q    <= 1'b0;
            last_q  <= 1'b1;
            cfg_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= SHIFT;
                        data_q  <= gnt1 ? req.req1_data : req.req0_data;
                        ch_q    <= gnt1;
                        last_q  <= gnt1;
                        cfg_q   <= '{pattern: cfg_pattern, len: cfg_len, overlap: cfg_overlap};
                        pos_q   <= '0;
                    end
                end
                SHIFT: begin
                    data_q <= {data_q[W-2:0], 1'b0};
                    pos_q  <= pos_q + POS_W'(1);
                    if (pos_q == POS_W'(W - 1))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    seq_match_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (grant),
        .bit_vld (state_q == SHIFT),
        .bit_in  (data_q[W-1]),
        .cfg     (cfg_q),
        .hit     (hit)
    );

    // Register the match report one cycle after the bit that completed it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            mch_q   <= 1'b0;
            mpos_q  <= '0;
        end else begin
            pulse_q <= hit;
            if (hit) begin
                mch_q  <= ch_q;
                mpos_q <= pos_q;
            end
        end
    end

    assign req.match_pulse = pulse_q;
    assign req.match_ch    = mch_q;
    assign req.match_pos   = mpos_q;

    // Counter next state; clear dominates a coincident increment.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (hit) begin
            if (!ch_q && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
            if ( ch_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    // Per-channel match counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign match_cnt0 = cnt0_q;
    assign match_cnt1 = cnt1_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// Bench for seq_detect_sched: directed scenarios plus random traffic, all
// checked every cycle against a frame-level reference model.
module tb_seq_detect_sched;
    import seq_detect_sched_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_en = 1'b0;
    logic [PW-1:0]    cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = LEN_W'(4);
    logic             cfg_overlap = 1'b0;
    logic             cfg_err;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] match_cnt0, match_cnt1;

    seq_detect_sched_if bus();

    seq_detect_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_err     (cfg_err),
        .cnt_clr     (cnt_clr),
        .match_cnt0  (match_cnt0),
        .match_cnt1  (match_cnt1),
        .req         (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycle index, when the detector frees up, expected reports.
    int   cyc = 0;
    int   free_at = 0;
    bit   last_ch = 1'b1;
    int   m_cnt [2];
    bit   ep [int];
    bit   ech [int];
    int   epos [int];
    bit   v [2];
    logic [W-1:0] d [2];
    bit   rearm [2];
    int   gq_cyc [$];
    bit   gq_ch [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected matches of a whole word: the last L bits of the MSB-first
    // prefix must equal the pattern, using only bits after the previous
    // match when overlap is off.
    function automatic void frame_hits(input int w, input int p, input int len,
                                       input bit ovl, input int g, input bit ch);
        int start = 0;
        int msk = (1 << len) - 1;
        for (int k = 0; k < W; k++) begin
            if (k + 1 - start >= len) begin
                if (((w >> (W - 1 - k)) & msk) == (p & msk)) begin
                    ep[g + 2 + k]   = 1'b1;
                    ech[g + 2 + k]  = ch;
                    epos[g + 2 + k] = k;
                    if (!ovl) start = k + 1;
                end
            end
        end
    endfunction

    function automatic void model_reset();
        ep.delete();
        ech.delete();
        epos.delete();
        free_at = 0;
        last_ch = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endfunction

    // One clock: drive requesters, check all outputs mid-cycle, advance model.
    task automatic step();
        bit ok, g0, g1, ch, bad;
        bus.req0_valid = v[0];
        bus.req0_data  = d[0];
        bus.req1_valid = v[1];
        bus.req1_data  = d[1];
        @(negedge clk);
        bad = (cfg_len == 0) || (int'(cfg_len) > PW);
        chk("cfg_err", cfg_err, bad);
        ok = rst_n && cfg_en && !bad && (cyc >= free_at);
        g0 = ok && v[0] && (!v[1] || last_ch);
        g1 = ok && v[1] && !g0;
        chk("rdy0", bus.req0_ready, g0);
        chk("rdy1", bus.req1_ready, g1);
        chk("busy", bus.busy, (cyc >= free_at - W) && (cyc < free_at));
        chk("pulse", bus.match_pulse, ep.exists(cyc));
        if (ep.exists(cyc)) begin
            chk("match_ch", bus.match_ch, ech[cyc]);
            chk("match_pos", bus.match_pos, epos[cyc]);
        end
        chk("cnt0", match_cnt0, m_cnt[0]);
        chk("cnt1", match_cnt1, m_cnt[1]);
        if (bus.req0_ready) begin gq_cyc.push_back(cyc); gq_ch.push_back(1'b0); end
        if (bus.req1_ready) begin gq_cyc.push_back(cyc); gq_ch.push_back(1'b1); end
        if (g0 || g1) begin
            ch = g1;
            frame_hits(int'(d[ch]), int'(cfg_pattern), int'(cfg_len), cfg_overlap, cyc, ch);
            free_at = cyc + W + 1;
            last_ch = ch;
            v[ch]   = rearm[ch];
        end
        if (cnt_clr) begin
            m_cnt[0] = 0;
            m_cnt[1] = 0;
        end else if (ep.exists(cyc + 1)) begin
            if (m_cnt[ech[cyc + 1]] < 65535) m_cnt[ech[cyc + 1]]++;
        end
        if (ep.exists(cyc)) begin
            ep.delete(cyc);
            ech.delete(cyc);
            epos.delete(cyc);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset mid-cycle, check outputs immediately, hold two cycles.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_busy"},  bus.busy, 1'b0);
        chk({tag, "_pulse"}, bus.match_pulse, 1'b0);
        chk({tag, "_ch"},    bus.match_ch, 1'b0);
        chk({tag, "_pos"},   bus.match_pos, 0);
        chk({tag, "_cnt0"},  match_cnt0, 0);
        chk({tag, "_cnt1"},  match_cnt1, 0);
        chk({tag, "_rdy0"},  bus.req0_ready, 1'b0);
        chk({tag, "_rdy1"},  bus.req1_ready, 1'b0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input logic [PW-1:0] p, input int len, input bit ovl);
        cfg_pattern = p;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        bit found;
        m_cnt[0] = 0; m_cnt[1] = 0;
        v[0] = 0; v[1] = 0; d[0] = '0; d[1] = '0;
        rearm[0] = 0; rearm[1] = 0;
        bus.req0_valid = 1'b0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0;
        @(posedge clk);
        #1;

        // Reset state, with a requester already waiting.
        cfg_en = 1'b1;
        set_cfg(8'b1010, 4, 1'b1);
        v[0] = 1; d[0] = 8'hAA;
        do_reset("rst0");

        // Overlapping 1010 in 0xAA: hits at 3, 5, 7.
        run(12);
        chk("ovl_cnt0", match_cnt0, 3);

        // Non-overlapping: hits at 3, 7.
        clear_cnt();
        set_cfg(8'b1010, 4, 1'b0);
        v[0] = 1; d[0] = 8'hAA;
        run(12);
        chk("novl_cnt0", match_cnt0, 2);

        // Frame isolation: 0x05 then 0x00 must not match across the boundary.
        clear_cnt();
        set_cfg(8'b1010, 4, 1'b1);
        v[0] = 1; d[0] = 8'h05;
        step();
        v[0] = 1; d[0] = 8'h00;
        run(22);
        chk("iso_cnt0", match_cnt0, 0);
        chk("iso_cnt1", match_cnt1, 0);

        // Both requesters valid from reset: ch0, ch1, ch0, ch1 every W+1 cycles.
        rearm[0] = 1; rearm[1] = 1;
        v[0] = 1; v[1] = 1; d[0] = 8'h3C; d[1] = 8'hC3;
        do_reset("rst1");
        gq_cyc.delete(); gq_ch.delete();
        run(40);
        chk("arb_n", gq_cyc.size(), 5);
        if (gq_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("arb_ch", gq_ch[i], i % 2);
            for (int i = 1; i < 4; i++) chk("arb_gap", gq_cyc[i] - gq_cyc[i-1], W + 1);
        end
        rearm[0] = 0; rearm[1] = 0; v[0] = 0; v[1] = 0;
        run(12);

        // Random traffic, config churn (including mid-frame and illegal lengths).
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (!v[c] && ($urandom % 4 == 0)) begin
                    v[c] = 1;
                    d[c] = W'($urandom);
                end
            end
            if ($urandom % 25 == 0) begin
                set_cfg(PW'($urandom), $urandom_range(0, 9), 1'($urandom));
                if ($urandom % 4 == 0) cfg_pattern = 8'hFF >> $urandom_range(4, 7);
                cfg_en = ($urandom % 8 != 0);
            end
            cnt_clr = ($urandom % 40 == 0);
            step();
        end
        cnt_clr = 1'b0;
        cfg_en = 1'b1;
        v[0] = 0; v[1] = 0;
        run(12);

        // Saturation on ch1, then clear coinciding with a hit.
        set_cfg(8'h01, 1, 1'b1);
        clear_cnt();
        rearm[1] = 1; v[1] = 1; d[1] = 8'hFF;
        for (int i = 0; i < 80000 && m_cnt[1] < 65535; i++) step();
        run(30);
        chk("sat_cnt1", match_cnt1, 16'hFFFF);
        chk("sat_cnt0", match_cnt0, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ep.exists(cyc + 1)) begin
                cnt_clr = 1'b1;
                step();
                cnt_clr = 1'b0;
                found = 1;
            end else begin
                step();
            end
        end
        chk("clr_found", found, 1'b1);
        chk("clr_on_hit", match_cnt1, 0);
        rearm[1] = 0; v[1] = 0;
        run(12);

        // Illegal length blocks grants.
        set_cfg(8'b1010, 0, 1'b1);
        v[0] = 1; d[0] = 8'hAA;
        run(5);
        chk("err_flag", cfg_err, 1'b1);
        chk("err_norun", match_cnt0, 0);

        // Reset at bit 4 of a ch0 frame; ch0 must still win first afterwards.
        set_cfg(8'b1010, 4, 1'b1);
        run(5);
        v[0] = 1; v[1] = 1; d[1] = 8'h55;
        do_reset("rst2");
        gq_cyc.delete(); gq_ch.delete();
        step();
        chk("post_rst_n", gq_ch.size(), 1);
        if (gq_ch.size() > 0) chk("post_rst_ch", gq_ch[0], 1'b0);
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Two-requester scheduler and serializer for the shared serial pattern detector. It arbitrates round-robin between two word-wide requesters and serializes the granted word MSB-first through one programmable Mealy-style detector. The detector pattern, length and overlap mode are configurable. The block reports each match with channel and bit position and keeps per-channel saturating match counters. It sits between the packet-side requesters and the status/interrupt logic.

## Interface
- W, 8: word width; bits per frame
- PW, 8: maximum pattern length
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_en  in  1  enables new grants; an in-flight frame always completes
- cfg_pattern  in  PW  pattern; bit [len-1] is compared against the oldest bit
- cfg_len  in  $clog2(PW+1)  pattern length; legal range 1..PW
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_err  out  1  combinational: cfg_len==0 or cfg_len>PW
- req0_valid / req1_valid  in  1  requester has a word
- req0_data / req1_data  in  W  word to scan
- req0_ready / req1_ready  out  1  grant; word accepted when valid&&ready
- busy  out  1  frame in progress (SHIFT state)
- match_pulse  out  1  registered one-cycle match strobe
- match_ch  out  1  channel of the reported match
- match_pos  out  $clog2(W)  bit index of completing bit (0 = MSB/first bit)
- cnt_clr  in  1  synchronous clear of both counters
- match_cnt0 / match_cnt1  out  16  saturating match counts

## Operation
- FSM states:
  - IDLE: if cfg_en && !cfg_err && any valid, grant one channel. The grant is a combinational ready in IDLE only. Latch data, channel, pattern, len and overlap, then go to SHIFT.
  - SHIFT: present one bit per cycle, MSB first, for W cycles. After the last bit, return to IDLE.
- Arbitration: if both channels are valid, grant the channel not granted last. After reset, ch0 has priority. A single valid channel is always granted.
- Detector is a history shift register hist[PW-1:0] plus a bit counter nb:
  - Each bit shifts into hist[0], and nb increments (saturating at PW).
  - Hit = (nb_after >= len) && (hist_after[len-1:0] == pattern[len-1:0]).
  - On a hit in non-overlap mode, nb resets to 0. In overlap mode nb is unchanged.
- Frame isolation: hist and nb clear at every grant. Matches never span words.
- Latched config is held for the whole frame. cfg_* changes take effect at the next grant.
- Counters:
  - A hit increments the counter of the frame's channel, saturating at 0xFFFF.
  - cnt_clr clears both counters. cnt_clr coinciding with an increment yields 0.
- cfg_en deasserted mid-frame: the frame finishes; no new grant is issued.
- cfg_err=1: no grants are issued.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; the frame is discarded.
  - hist, nb, match_pulse, match_ch, match_pos, counters and busy are 0; both readies are 0 while rst_n is low.
  - Arbitration priority returns to ch0.

## Timing
- Grant at cycle T (valid&&ready high at the edge ending T).
- Bit k is evaluated at cycle T+1+k, for k=0..W-1. busy=1 during T+1..T+W.
- match_pulse, match_ch, match_pos and the counter update appear at T+2+k, lasting one cycle per hit.
- Earliest next grant is T+W+1, giving a throughput of one word per W+1 cycles. The last match_pulse of frame n may coincide with the grant of frame n+1.
- Ready is never asserted in SHIFT. A requester must hold valid and data stable until accepted.

## Structure
- A shared package holds:
  - the FSM state enum {IDLE, SHIFT};
  - localparam CNT_W=16 and CNT_MAX=16'hFFFF;
  - a cfg struct {pattern, len, overlap} used for the latched copy.
- One sub-module, seq_match_core: the hist/nb detector with inputs clk, rst_n, clr, bit_vld, bit_in, cfg struct and output hit. Arbitration, FSM, serializer and counters live in the top.

## Test plan
- Overlap on, pattern 4'b1010, len 4, ch0 word 0xAA -> hits at pos 3, 5, 7; match_cnt0=3.
- Overlap off, same word -> hits at pos 3, 7; match_cnt0=2.
- Frame isolation: ch0 0x05 then ch0 0x00 with pattern 1010/len 4 -> no match_pulse at all; counters stay 0.
- Both requesters valid continuously from reset -> grants ch0, ch1, ch0, ch1 at cycles T, T+9, T+18, T+27 (W=8); busy low for exactly one cycle between frames.
- Saturation and clear: preload match_cnt1 to 0xFFFF via repeated hits -> stays 0xFFFF. Assert cnt_clr on a hit cycle -> 0.
- cfg_len=0 -> cfg_err=1 with no ready. Then rst_n low mid-frame at bit 4 -> next cycle busy=0, all outputs 0; after release, ch0 is granted first.
